risc_mem_arbiter: RTL and testbench
===================================

Name: risc_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the 16-bit RISC core's instruction-fetch port and its load/store (data) port.
- Arbitrates requests and sequences each access through a small FSM.
- Returns read data and a one-cycle valid pulse to the winning requester.
- Sits between the core (Risc_16_bit datapath) and the unified instruction/data memory.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory.
- DATA_W, 16, data width.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch read data, registered.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only).
- d_rdata  out  DATA_W  data read data, registered.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, valid with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock domain on clk. Asynchronous, active-high reset.
- Reset values: all outputs 0. State IDLE, starvation counter 0, latency counter 0.
- Registered outputs: every output is driven from a register; no combinational path from input to output.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples if_req and d_req.
  - No request: stays in IDLE.
  - Otherwise, at the edge, picks a winner and moves to ISSUE.
  - Registers mem_en=1, mem_we, mem_addr, mem_wdata and the winner's gnt=1, all valid during the ISSUE cycle.
- Arbitration priority:
  - Data beats fetch.
  - Exception: if starve_cnt == STARVE_MAX and if_req=1, fetch wins.
- Starvation counter (starve_cnt):
  - Increments when if_req=1 and data wins; saturates at STARVE_MAX.
  - Clears when fetch is granted or if_req=0 in IDLE.
- ISSUE, one cycle:
  - Winning write: next state IDLE. No rvalid. Write occupancy is 2 cycles.
  - Winning read: next state WAIT and load the latency counter with MEM_LAT.
- WAIT:
  - Decrement the latency counter.
  - At the edge ending the cycle where mem_rdata is valid (MEM_LAT cycles after ISSUE), capture mem_rdata into the winner's rdata register.
  - Go to RESP.
- RESP, one cycle: winner's rvalid=1, then return to IDLE.
  - Read occupancy is MEM_LAT+2 cycles; with MEM_LAT=1, one read per 3 cycles.
  - Arbitration reopens at the edge ending RESP; no bubble beyond that.
- Read latency: req sampled at edge E0 -> gnt in cycle E0+1 -> rvalid in cycle E0+2+MEM_LAT.
- Requests are sampled only in IDLE.
  - A req dropped before gnt is withdrawn without any memory access.
  - A req changed in non-IDLE states is ignored.
- Simultaneous if_req and d_req: one winner per rule above. The loser stays pending (requester holds req) and is reconsidered in the next IDLE.
- The rdata registers hold their last value between reads. Only the winner's rdata is updated.
- Reset mid-operation (ISSUE, WAIT or RESP): immediately IDLE, outputs 0, pending read discarded, no rvalid.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds outputs perf_if_stall[15:0] and perf_d_stall[15:0].
  - Each counts the cycles its req=1 without gnt=1 on the same port.
  - Saturating at 16'hFFFF; cleared by reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset check: assert reset mid-sim -> all outputs 0, busy=0 within the same cycle (asynchronous).
- Single fetch read, MEM_LAT=1, memory model holds 16'hA5A5 at address 16'h0010:
  - if_req at E0 -> if_gnt in cycle 1, mem_en=1 with mem_addr=16'h0010 in cycle 1.
  - if_rvalid=1 with if_rdata=16'hA5A5 in cycle 3.
- Data write: d_req, d_we=1, d_addr=16'h0020, d_wdata=16'h1234.
  - mem_en=mem_we=1 for exactly one cycle with those values.
  - No d_rvalid; next grant possible 2 cycles after the first.
- Simultaneous if_req and d_req (read):
  - d_gnt first, then d_rvalid.
  - if_gnt in the cycle after RESP.
- Starvation, STARVE_MAX=4:
  - Hold if_req and d_req continuously -> data granted 4 times, then fetch granted on the 5th arbitration.
  - Pattern repeats.
- Reset asserted during WAIT with MEM_LAT=3 -> no rvalid ever appears for that read; the next request is served normally.
- Under MEM_ARB_PERF_EN, in the starvation scenario: perf_if_stall matches the cycle count measured by the bench.

Source files
------------

// File: rtl/risc_mem_arbiter.sv
// Arbitrates the 16-bit RISC core's fetch and load/store ports onto one single-port synchronous memory.
// Optional MEM_ARB_PERF_EN adds per-port stall counters (perf_if_stall / perf_d_stall).
module risc_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_if_stall,
  output logic [15:0]       perf_d_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q;
  logic [3:0]        starve_q, starve_d;
  logic [2:0]        lat_q;
  logic              fetch_own_q;
  logic              if_gnt_q, if_rvalid_q, d_gnt_q, d_rvalid_q;
  logic              mem_en_q, mem_we_q, busy_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              arb_open, fetch_win_d, data_win_d;

  // Arbitration is open in IDLE and at the edge ending RESP, so back-to-back reads need no bubble.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch can be inferred.
    arb_open    = (state_q == IDLE) || (state_q == RESP);
    fetch_win_d = arb_open && if_req && (!d_req || (starve_q == 4'(STARVE_MAX)));
    data_win_d  = arb_open && d_req && !fetch_win_d;
    starve_d    = starve_q;
    if (arb_open) begin
      if (fetch_win_d || !if_req) begin
        starve_d = '0;
      end else if (starve_q != 4'(STARVE_MAX)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the read-data holding registers are reset too; they are outputs that must read 0.
      state_q     <= IDLE;
      starve_q    <= '0;
      lat_q       <= '0;
      fetch_own_q <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments; pulses default low and are raised only by the branch below.
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        IDLE, RESP: begin
          if (fetch_win_d || data_win_d) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= data_win_d && d_we;
            mem_addr_q  <= data_win_d ? d_addr : if_addr;
            mem_wdata_q <= data_win_d ? d_wdata : '0;
            if_gnt_q    <= fetch_win_d;
            d_gnt_q     <= data_win_d;
            fetch_own_q <= fetch_win_d;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ISSUE: begin
          mem_we_q <= 1'b0;
          if (mem_we_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT;
            lat_q   <= 3'(MEM_LAT);
          end
        end
        WAIT: begin
          lat_q <= lat_q - 3'd1;
          // Last wait cycle is the one in which the memory presents the data.
          if (lat_q == 3'd1) begin
            state_q <= RESP;
            if (fetch_own_q) begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end else begin
              d_rdata_q  <= mem_rdata;
              d_rvalid_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_if_q, perf_d_q;

  // A stall cycle is one where the port requests but is not granted in that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_if_q <= '0;
      perf_d_q  <= '0;
    end else begin
      if (if_req && !if_gnt_q && (perf_if_q != 16'hFFFF)) perf_if_q <= perf_if_q + 16'd1;
      if (d_req && !d_gnt_q && (perf_d_q != 16'hFFFF))    perf_d_q  <= perf_d_q + 16'd1;
    end
  end

  assign perf_if_stall = perf_if_q;
  assign perf_d_stall  = perf_d_q;
`endif

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Scoreboard bench for risc_mem_arbiter: directed timing cases on MEM_LAT=1 and MEM_LAT=3 instances
// plus randomized traffic checked against a transaction-level memory model.
`timescale 1ns/1ps
module tb_risc_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req3;
  logic [15:0] if_addr3;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
  logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_if_stall, perf_d_stall, perf_if_stall3, perf_d_stall3;
`endif

  risc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
`endif
  );

  risc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall3), .perf_d_stall(perf_d_stall3)
`endif
  );

  // Memory contents: sparse array over a fixed address-derived background pattern.
  logic [15:0] mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    return {a[7:0], ~a[15:8]} ^ 16'h3C69;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Synchronous memories with 1- and 3-cycle read latency; 16'hDEAD when no read data is due.
  logic        v1 = 1'b0;
  logic [15:0] d1;
  logic [2:0]  v3 = 3'b000;
  logic [15:0] d3 [3];

  always @(posedge clk) begin
    v1    <= mem_en && !mem_we;
    d1    <= mem_rd(mem_addr);
    v3    <= {v3[1:0], mem_en3 && !mem_we3};
    d3[0] <= mem_rd(mem_addr3);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
  end

  assign mem_rdata  = v1 ? d1 : 16'hDEAD;
  assign mem_rdata3 = v3[2] ? d3[2] : 16'hDEAD;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard: expected read data per port, popped whenever the DUT raises rvalid.
  logic [15:0] exp_if_q[$];
  logic [15:0] exp_d_q[$];
  logic [15:0] exp3_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (if_rvalid) begin
        if (exp_if_q.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid), 32'h0);
        else check("if_rdata", 32'(if_rdata), 32'(exp_if_q.pop_front()));
      end
      if (d_rvalid) begin
        if (exp_d_q.size() == 0) check("d_rvalid_unexpected", 32'(d_rvalid), 32'h0);
        else check("d_rdata", 32'(d_rdata), 32'(exp_d_q.pop_front()));
      end
      if (if_rvalid3) begin
        if (exp3_q.size() == 0) check("lat3_rvalid_unexpected", 32'(if_rvalid3), 32'h0);
        else check("lat3_rdata", 32'(if_rdata3), 32'(exp3_q.pop_front()));
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  int stall_if, stall_d;
  always @(posedge clk) begin
    if (reset) begin
      stall_if <= 0;
      stall_d  <= 0;
    end else begin
      if (if_req && !if_gnt) stall_if <= stall_if + 1;
      if (d_req && !d_gnt)   stall_d  <= stall_d + 1;
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int   t, rv_seen, rv_at, drain_t;
  int   f_gap, f_t, d_gap, d_t;
  logic exp_f;

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0;
    repeat (3) step();
    check("reset_ctrl", 32'({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}), 32'h0);
    check("reset_rdata", {if_rdata, d_rdata}, 32'h0);
    check("reset_mem_bus", {mem_addr, mem_wdata}, 32'h0);
    reset = 1'b0;
    step();
    check("idle_ctrl", 32'({if_gnt, d_gnt, mem_en, busy}), 32'h0);

    // Single fetch read, MEM_LAT=1: gnt in cycle 1, rvalid in cycle 3.
    exp_if_q.push_back(16'hA5A5);
    if_addr = 16'h0010; if_req = 1'b1;
    step();
    check("fetch_gnt_c1", 32'({if_gnt, d_gnt}), 32'h2);
    check("fetch_mem_c1", 32'({mem_en, mem_we, busy}), 32'h5);
    check("fetch_mem_addr", 32'(mem_addr), 32'h0010);
    if_req = 1'b0;
    step();
    check("fetch_rvalid_c2", 32'(if_rvalid), 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0099;
    step();
    check("fetch_rvalid_c3", 32'(if_rvalid), 32'h1);
    check("fetch_rdata_c3", 32'(if_rdata), 32'hA5A5);
    d_req = 1'b0;
    step();
    check("withdrawn_no_access", 32'({mem_en, d_gnt, if_gnt, busy}), 32'h0);

    // Data writes: one-cycle strobe, next grant two cycles after the first.
    d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234; d_req = 1'b1;
    ref_mem[16'h0020] = 16'h1234;
    step();
    check("wr_gnt", 32'({if_gnt, d_gnt}), 32'h1);
    check("wr_strobe", 32'({mem_en, mem_we}), 32'h3);
    check("wr_bus", {mem_addr, mem_wdata}, {16'h0020, 16'h1234});
    d_addr = 16'h0021; d_wdata = 16'h5678;
    ref_mem[16'h0021] = 16'h5678;
    step();
    check("wr_gap", 32'({mem_en, mem_we, d_gnt, busy}), 32'h0);
    step();
    check("wr_next_gnt", 32'({d_gnt, mem_en, mem_we}), 32'h7);
    check("wr2_bus", {mem_addr, mem_wdata}, {16'h0021, 16'h5678});
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("wr_done", 32'({mem_en, mem_we, busy, d_rvalid}), 32'h0);

    // Simultaneous requests: data first, fetch granted in the cycle after RESP.
    if_addr = 16'h0030; if_req = 1'b1; d_addr = 16'h0020; d_we = 1'b0; d_req = 1'b1;
    exp_d_q.push_back(ref_rd(16'h0020));
    exp_if_q.push_back(ref_rd(16'h0030));
    step();
    check("sim_first_gnt", 32'({if_gnt, d_gnt}), 32'h1);
    d_req = 1'b0;
    step();
    step();
    check("sim_d_rvalid", 32'({if_rvalid, d_rvalid, if_gnt}), 32'h2);
    step();
    check("sim_if_gnt", 32'({if_gnt, d_gnt}), 32'h2);
    check("sim_if_addr", 32'(mem_addr), 32'h0030);
    if_req = 1'b0;
    step();
    step();
    check("sim_if_rvalid", 32'(if_rvalid), 32'h1);
    step();

    // Starvation: continuous requests give D D D D F, repeating.
    if_addr = 16'h0040; if_req = 1'b1; d_addr = 16'h0021; d_we = 1'b0; d_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      exp_f = (g % 5 == 4);
      if (exp_f) exp_if_q.push_back(ref_rd(16'h0040));
      else exp_d_q.push_back(ref_rd(16'h0021));
      t = 0;
      step();
      while (!(if_gnt || d_gnt) && t < 10) begin
        step();
        t++;
      end
      check($sformatf("starve_grant%0d", g), 32'({if_gnt, d_gnt}), exp_f ? 32'h2 : 32'h1);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) step();
`ifdef MEM_ARB_PERF_EN
    check("perf_if_stall", 32'(perf_if_stall), 32'(stall_if));
    check("perf_d_stall", 32'(perf_d_stall), 32'(stall_d));
`endif

    // Reset during WAIT on the MEM_LAT=3 instance: read discarded, next read served normally.
    if_addr3 = 16'h0050; if_req3 = 1'b1;
    step();
    check("lat3_gnt", 32'(if_gnt3), 32'h1);
    if_req3 = 1'b0;
    step();
    check("lat3_busy_wait", 32'({busy3, mem_en3}), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("async_reset_lat3", 32'({if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3}), 32'h0);
    check("async_reset_lat3_bus", {mem_addr3, if_rdata3}, 32'h0);
    check("async_reset_lat1_rdata", {if_rdata, d_rdata}, 32'h0);
    step();
    reset = 1'b0;
    rv_seen = 0;
    repeat (8) begin
      step();
      if (if_rvalid3) rv_seen++;
    end
    check("lat3_no_rvalid_after_reset", 32'(rv_seen), 32'h0);
    if_addr3 = 16'h0051; if_req3 = 1'b1;
    exp3_q.push_back(ref_rd(16'h0051));
    step();
    check("lat3_gnt2", 32'(if_gnt3), 32'h1);
    if_req3 = 1'b0;
    rv_at = 0;
    for (int k = 2; k <= 7; k++) begin
      step();
      if (if_rvalid3 && rv_at == 0) rv_at = k;
    end
    check("lat3_rvalid_cycle", 32'(rv_at), 32'h5);

    // Randomized traffic on both ports; fetch and data use disjoint address regions.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          f_gap = $urandom_range(0, 3);
          repeat (f_gap) step();
          if_addr = 16'h1000 | 16'($urandom_range(0, 255));
          if_req = 1'b1;
          exp_if_q.push_back(ref_rd(if_addr));
          f_t = 0;
          step();
          while (!if_gnt && f_t < 40) begin
            step();
            f_t++;
          end
          if (!if_gnt) check("rnd_if_gnt_timeout", 32'(if_gnt), 32'h1);
          if_req = 1'b0;
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          d_gap = $urandom_range(0, 3);
          repeat (d_gap) step();
          d_we = 1'($urandom_range(0, 1));
          d_addr = 16'h2000 | 16'($urandom_range(0, 15));
          d_wdata = 16'($urandom);
          if (d_we) ref_mem[d_addr] = d_wdata;
          else exp_d_q.push_back(ref_rd(d_addr));
          d_req = 1'b1;
          d_t = 0;
          step();
          while (!d_gnt && d_t < 40) begin
            step();
            d_t++;
          end
          if (!d_gnt) check("rnd_d_gnt_timeout", 32'(d_gnt), 32'h1);
          d_req = 1'b0;
        end
      end
    join

    drain_t = 0;
    while ((exp_if_q.size() + exp_d_q.size() + exp3_q.size()) != 0 && drain_t < 30) begin
      step();
      drain_t++;
    end
    check("scoreboard_drained", 32'(exp_if_q.size() + exp_d_q.size() + exp3_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
